// File: rtl/ibi_sched_pkg.sv
// Shared types and constants for the IBI / Hot-Join retry scheduler.
package ibi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    WAIT_DONE,
    BACKOFF,
    REPORT
  } ibi_state_e;

  localparam logic [1:0] IBI_ST_OK        = 2'b00;
  localparam logic [1:0] IBI_ST_EXHAUSTED = 2'b01;
  localparam logic [1:0] IBI_ST_ABORT     = 2'b10;
  localparam logic [1:0] IBI_ST_TIMEOUT   = 2'b11;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] mdb;
    logic       is_hj;
  } ibi_req_t;

endpackage

// File: rtl/ibi_backoff_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ibi_backoff_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ibi_retry_scheduler.sv
// Sequences IBI and Hot-Join requests to the target FSM with NACK retry/backoff.
// Define IBI_TIMEOUT_EN to add a WAIT_DONE watchdog reporting status 11.
module ibi_retry_scheduler
  import ibi_sched_pkg::*;
#(
  parameter int BACKOFF_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ibi_enable_i,
  input  logic [2:0] ibi_retry_num_i,
  input  logic [6:0] target_ibi_addr_i,
  input  logic       target_ibi_addr_valid_i,
  input  logic [6:0] target_hot_join_addr_i,
  input  logic       hot_join_en_i,
  input  logic       bus_available_i,
  input  logic       ibi_req_valid_i,
  output logic       ibi_req_ready_o,
  input  logic [7:0] ibi_mdb_i,
  input  logic       hj_req_i,
  output logic       ibi_start_o,
  output logic [6:0] ibi_addr_o,
  output logic [7:0] ibi_mdb_o,
  output logic       ibi_is_hj_o,
  input  logic       ibi_done_i,
  input  logic       ibi_ack_i,
  output logic       status_valid_o,
  output logic [1:0] status_o,
  output logic       busy_o
);

  localparam int MAX_CYCLES = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] BACKOFF_LOAD = TW'(BACKOFF_CYCLES - 1);
`ifdef IBI_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
`endif

  ibi_state_e state_q, state_d;
  ibi_req_t   req_q;
  logic [2:0] retry_q;
  logic [1:0] status_q, status_d;
  logic       hj_pending_q;
  logic       latch_ibi, latch_hj, retry_inc;
  logic       timer_load, timer_expired;
  logic [TW-1:0] timer_value;
  logic       type_en;

  // An in-flight request aborts when the enable matching its own type drops.
  assign type_en = req_q.is_hj ? hot_join_en_i : ibi_enable_i;

  ibi_backoff_timer #(.WIDTH(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      status_q <= IBI_ST_OK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    status_d        = status_q;
    ibi_req_ready_o = 1'b0;
    ibi_start_o     = 1'b0;
    latch_ibi       = 1'b0;
    latch_hj        = 1'b0;
    retry_inc       = 1'b0;
    timer_load      = 1'b0;
    timer_value     = BACKOFF_LOAD;
    unique case (state_q)
      IDLE: begin
        if (hj_pending_q) begin
          latch_hj = 1'b1;
          state_d  = WAIT_BUS;
        end else if (ibi_req_valid_i && ibi_enable_i && target_ibi_addr_valid_i && rst_ni) begin
          ibi_req_ready_o = 1'b1;
          latch_ibi       = 1'b1;
          state_d         = WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        if (!type_en) begin
          status_d = IBI_ST_ABORT;
          state_d  = REPORT;
        end else if (bus_available_i) begin
          ibi_start_o = 1'b1;
          state_d     = WAIT_DONE;
`ifdef IBI_TIMEOUT_EN
          timer_load  = 1'b1;
          timer_value = TIMEOUT_LOAD;
`endif
        end
      end
      WAIT_DONE: begin
        // A live decrease of the retry limit below the count must still terminate.
        if (ibi_done_i) begin
          if (ibi_ack_i) begin
            status_d = IBI_ST_OK;
            state_d  = REPORT;
          end else if (retry_q >= ibi_retry_num_i) begin
            status_d = IBI_ST_EXHAUSTED;
            state_d  = REPORT;
          end else begin
            retry_inc  = 1'b1;
            timer_load = 1'b1;
            state_d    = BACKOFF;
          end
        end
`ifdef IBI_TIMEOUT_EN
        else if (timer_expired) begin
          status_d = IBI_ST_TIMEOUT;
          state_d  = REPORT;
        end
`endif
      end
      BACKOFF: begin
        if (!type_en) begin
          status_d = IBI_ST_ABORT;
          state_d  = REPORT;
        end else if (timer_expired) begin
          state_d = WAIT_BUS;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (latch_hj) begin
      req_q <= '{addr: target_hot_join_addr_i, mdb: 8'h00, is_hj: 1'b1};
    end else if (latch_ibi) begin
      req_q <= '{addr: target_ibi_addr_i, mdb: ibi_mdb_i, is_hj: 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_q <= '0;
    end else if (state_q == REPORT) begin
      retry_q <= '0;
    end else if (retry_inc && retry_q != 3'd7) begin
      retry_q <= retry_q + 3'd1;
    end
  end

  // Level clears are equivalent to the edge clears because setting needs en=1 and addr_valid=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hj_pending_q <= 1'b0;
    end else if (!hot_join_en_i || target_ibi_addr_valid_i) begin
      hj_pending_q <= 1'b0;
    end else if (state_q == REPORT && req_q.is_hj) begin
      hj_pending_q <= 1'b0;
    end else if (hj_req_i) begin
      hj_pending_q <= 1'b1;
    end
  end

  assign ibi_addr_o     = req_q.addr;
  assign ibi_mdb_o      = req_q.mdb;
  assign ibi_is_hj_o    = req_q.is_hj;
  assign status_valid_o = (state_q == REPORT);
  assign status_o       = (state_q == REPORT) ? status_q : IBI_ST_OK;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ibi_retry_scheduler.sv
// Directed self-checking bench for ibi_retry_scheduler (BACKOFF_CYCLES=16, TIMEOUT_CYCLES=8).
module tb_ibi_retry_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ibi_enable_i = 1'b1;
  logic [2:0] ibi_retry_num_i = 3'd0;
  logic [6:0] target_ibi_addr_i = 7'h00;
  logic       target_ibi_addr_valid_i = 1'b1;
  logic [6:0] target_hot_join_addr_i = 7'h02;
  logic       hot_join_en_i = 1'b1;
  logic       bus_available_i = 1'b1;
  logic       ibi_req_valid_i = 1'b0;
  logic       ibi_req_ready_o;
  logic [7:0] ibi_mdb_i = 8'h00;
  logic       hj_req_i = 1'b0;
  logic       ibi_start_o;
  logic [6:0] ibi_addr_o;
  logic [7:0] ibi_mdb_o;
  logic       ibi_is_hj_o;
  logic       ibi_done_i = 1'b0;
  logic       ibi_ack_i = 1'b0;
  logic       status_valid_o;
  logic [1:0] status_o;
  logic       busy_o;

  ibi_retry_scheduler #(.BACKOFF_CYCLES(16), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ibi_enable_i(ibi_enable_i),
    .ibi_retry_num_i(ibi_retry_num_i), .target_ibi_addr_i(target_ibi_addr_i),
    .target_ibi_addr_valid_i(target_ibi_addr_valid_i),
    .target_hot_join_addr_i(target_hot_join_addr_i), .hot_join_en_i(hot_join_en_i),
    .bus_available_i(bus_available_i), .ibi_req_valid_i(ibi_req_valid_i),
    .ibi_req_ready_o(ibi_req_ready_o), .ibi_mdb_i(ibi_mdb_i), .hj_req_i(hj_req_i),
    .ibi_start_o(ibi_start_o), .ibi_addr_o(ibi_addr_o), .ibi_mdb_o(ibi_mdb_o),
    .ibi_is_hj_o(ibi_is_hj_o), .ibi_done_i(ibi_done_i), .ibi_ack_i(ibi_ack_i),
    .status_valid_o(status_valid_o), .status_o(status_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int check_count = 0;
  int fail_count = 0;

  int cycle_cnt = 0, start_cnt = 0, ready_cnt = 0, status_cnt = 0;
  int last_start_cycle = 0, last_status_cycle = 0;
  logic [6:0] start_addr = '0;
  logic [7:0] start_mdb = '0;
  logic       start_hj = 1'b0;
  logic [1:0] last_status = '0;

  // Monitor samples on the falling edge, well away from the active edge.
  always @(negedge clk_i) begin
    cycle_cnt <= cycle_cnt + 1;
    if (ibi_start_o) begin
      start_cnt        <= start_cnt + 1;
      last_start_cycle <= cycle_cnt;
      start_addr       <= ibi_addr_o;
      start_mdb        <= ibi_mdb_o;
      start_hj         <= ibi_is_hj_o;
    end
    if (ibi_req_ready_o) ready_cnt <= ready_cnt + 1;
    if (status_valid_o) begin
      status_cnt        <= status_cnt + 1;
      last_status_cycle <= cycle_cnt;
      last_status       <= status_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] mdb);
    target_ibi_addr_i = addr;
    ibi_mdb_i         = mdb;
    ibi_req_valid_i   = 1'b1;
    step(1);
    ibi_req_valid_i   = 1'b0;
  endtask

  task automatic respond(input logic ack);
    ibi_done_i = 1'b1;
    ibi_ack_i  = ack;
    step(1);
    ibi_done_i = 1'b0;
    ibi_ack_i  = 1'b0;
  endtask

  task automatic attempt(input int target, input logic ack, input string tag);
    int n = 0;
    while (start_cnt < target && n < 200) begin
      step(1);
      n++;
    end
    checkOutput({tag, "_start_seen"}, 32'(start_cnt >= target), 32'd1);
    if (start_cnt >= target) respond(ack);
  endtask

  task automatic wait_status(input int target, input string tag);
    int n = 0;
    while (status_cnt < target && n < 300) begin
      step(1);
      n++;
    end
    checkOutput({tag, "_status_seen"}, 32'(status_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int s0, r0, st0, c1, c2, c3;

    #2;
    checkOutput("reset_outputs",
                {ibi_req_ready_o, ibi_start_o, ibi_addr_o, ibi_mdb_o, ibi_is_hj_o,
                 status_valid_o, status_o, busy_o}, 32'd0);
    step(2);
    rst_ni = 1'b1;
    step(2);
    checkOutput("idle_busy", busy_o, 0);

    // 1: single attempt, ACK
    s0 = start_cnt; r0 = ready_cnt; st0 = status_cnt;
    ibi_retry_num_i = 3'd0;
    applyStimulus(7'h2A, 8'hA5);
    attempt(s0 + 1, 1'b1, "t1");
    wait_status(st0 + 1, "t1");
    checkOutput("t1_addr", start_addr, 7'h2A);
    checkOutput("t1_mdb", start_mdb, 8'hA5);
    checkOutput("t1_is_hj", start_hj, 0);
    checkOutput("t1_status", last_status, 2'b00);
    checkOutput("t1_ready_pulses", ready_cnt - r0, 1);
    checkOutput("t1_start_pulses", start_cnt - s0, 1);
    step(1);
    checkOutput("t1_busy_after", busy_o, 0);

    // 2: retry_num=2, all NACK -> 3 attempts spaced by 18 cycles
    s0 = start_cnt; st0 = status_cnt;
    ibi_retry_num_i = 3'd2;
    applyStimulus(7'h2A, 8'h3C);
    attempt(s0 + 1, 1'b0, "t2a"); c1 = last_start_cycle;
    attempt(s0 + 2, 1'b0, "t2b"); c2 = last_start_cycle;
    attempt(s0 + 3, 1'b0, "t2c"); c3 = last_start_cycle;
    wait_status(st0 + 1, "t2");
    checkOutput("t2_start_pulses", start_cnt - s0, 3);
    checkOutput("t2_gap1", c2 - c1, 18);
    checkOutput("t2_gap2", c3 - c2, 18);
    checkOutput("t2_status", last_status, 2'b01);

    // 2b: retry_num=0 with NACK -> exactly one attempt
    s0 = start_cnt; st0 = status_cnt;
    ibi_retry_num_i = 3'd0;
    applyStimulus(7'h15, 8'h01);
    attempt(s0 + 1, 1'b0, "t2z");
    wait_status(st0 + 1, "t2z");
    checkOutput("t2z_status", last_status, 2'b01);
    checkOutput("t2z_start_pulses", start_cnt - s0, 1);

    // 3: HJ wins over an IBI whose address is not valid
    s0 = start_cnt; r0 = ready_cnt; st0 = status_cnt;
    target_ibi_addr_valid_i = 1'b0;
    ibi_req_valid_i = 1'b1;
    ibi_mdb_i = 8'h77;
    hj_req_i = 1'b1;
    step(1);
    hj_req_i = 1'b0;
    step(1);
    hj_req_i = 1'b1;
    step(1);
    hj_req_i = 1'b0;
    attempt(s0 + 1, 1'b1, "t3");
    wait_status(st0 + 1, "t3");
    checkOutput("t3_addr", start_addr, 7'h02);
    checkOutput("t3_mdb", start_mdb, 8'h00);
    checkOutput("t3_is_hj", start_hj, 1);
    checkOutput("t3_status", last_status, 2'b00);
    step(30);
    checkOutput("t3_no_second_hj", start_cnt - s0, 1);
    checkOutput("t3_ibi_not_taken", ready_cnt - r0, 0);
    ibi_req_valid_i = 1'b0;
    target_ibi_addr_valid_i = 1'b1;
    step(1);

    // 4: abort while waiting for the bus; ready only pulses in IDLE
    s0 = start_cnt; r0 = ready_cnt; st0 = status_cnt;
    bus_available_i = 1'b0;
    target_ibi_addr_i = 7'h11;
    ibi_mdb_i = 8'h22;
    ibi_req_valid_i = 1'b1;
    step(4);
    ibi_req_valid_i = 1'b0;
    checkOutput("t4_busy", busy_o, 1);
    checkOutput("t4_ready_once", ready_cnt - r0, 1);
    ibi_enable_i = 1'b0;
    wait_status(st0 + 1, "t4");
    checkOutput("t4_status", last_status, 2'b10);
    checkOutput("t4_no_start", start_cnt - s0, 0);
    step(1);
    checkOutput("t4_idle", busy_o, 0);
    ibi_enable_i = 1'b1;
    bus_available_i = 1'b1;

    // 4b: abort during backoff
    s0 = start_cnt; st0 = status_cnt;
    ibi_retry_num_i = 3'd1;
    applyStimulus(7'h33, 8'h44);
    attempt(s0 + 1, 1'b0, "t4b");
    step(3);
    ibi_enable_i = 1'b0;
    wait_status(st0 + 1, "t4b");
    checkOutput("t4b_status", last_status, 2'b10);
    checkOutput("t4b_start_pulses", start_cnt - s0, 1);
    ibi_enable_i = 1'b1;
    step(1);

    // 5: reset in WAIT_DONE, then a stray done while IDLE
    s0 = start_cnt;
    applyStimulus(7'h55, 8'h66);
    while (start_cnt == s0 && cycle_cnt < 5000) step(1);
    step(2);
    rst_ni = 1'b0;
    #1;
    checkOutput("t5_reset_outputs",
                {ibi_req_ready_o, ibi_start_o, ibi_addr_o, ibi_mdb_o, ibi_is_hj_o,
                 status_valid_o, status_o, busy_o}, 32'd0);
    step(2);
    rst_ni = 1'b1;
    st0 = status_cnt;
    step(5);
    respond(1'b1);
    step(20);
    checkOutput("t5_no_status", status_cnt - st0, 0);
    checkOutput("t5_idle", busy_o, 0);

    // 6: watchdog (or its absence)
    s0 = start_cnt; st0 = status_cnt;
    ibi_retry_num_i = 3'd0;
    applyStimulus(7'h0F, 8'hF0);
`ifdef IBI_TIMEOUT_EN
    wait_status(st0 + 1, "t6");
    checkOutput("t6_status", last_status, 2'b11);
    checkOutput("t6_latency", last_status_cycle - last_start_cycle, 9);
    checkOutput("t6_start_pulses", start_cnt - s0, 1);
`else
    step(40);
    checkOutput("t6_still_waiting", status_cnt - st0, 0);
    checkOutput("t6_busy", busy_o, 1);
    respond(1'b1);
    wait_status(st0 + 1, "t6");
    checkOutput("t6_status", last_status, 2'b00);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ibi_retry_scheduler.md
Name: ibi_retry_scheduler

Overview:
- Sequences target-initiated bus requests: In-Band Interrupts (IBI) from the TTI IBI queue and Hot-Join (HJ) requests.
- Waits for bus-available, issues one request at a time to the target bus FSM, and retries on NACK or lost arbitration up to the CSR-programmed retry count.
- Reports one completion status per request.
- Sits between the configuration block outputs (ibi_enable, ibi_retry_num, IBI/HJ addresses), the bus timers (bus available) and the target FSM.

Parameters:
- BACKOFF_CYCLES, 16: idle cycles inserted after a NACK before re-checking bus_available_i.
- TIMEOUT_CYCLES, 4096: WAIT_DONE watchdog limit; only used with IBI_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ibi_enable_i  in  1  TTI CONTROL.IBI_EN
- ibi_retry_num_i  in  3  maximum retries after the first attempt
- target_ibi_addr_i  in  7  IBI address (dynamic if valid, else static)
- target_ibi_addr_valid_i  in  1  IBI address usable
- target_hot_join_addr_i  in  7  HJ address, fixed 7'h02
- hot_join_en_i  in  1  HJ permitted (cleared by DISEC)
- bus_available_i  in  1  level from the bus timers
- ibi_req_valid_i  in  1  IBI queue entry valid
- ibi_req_ready_o  out  1  entry accepted
- ibi_mdb_i  in  8  mandatory data byte of the entry
- hj_req_i  in  1  single-cycle HJ request pulse
- ibi_start_o  out  1  single-cycle launch pulse to the target FSM
- ibi_addr_o  out  7  address to arbitrate with
- ibi_mdb_o  out  8  MDB to send (0 for HJ)
- ibi_is_hj_o  out  1  current request is HJ
- ibi_done_i  in  1  target FSM attempt-finished pulse
- ibi_ack_i  in  1  qualifies ibi_done_i: 1 = ACKed, 0 = NACK or arbitration lost
- status_valid_o  out  1  single-cycle completion pulse
- status_o  out  2  00 success, 01 retries exhausted, 10 aborted, 11 timeout
- busy_o  out  1  state is not IDLE

Behaviour:
Reset values:
- All outputs are 0, state is IDLE, hj_pending is 0, the retry counter is 0.

HJ pending flag:
- Set by hj_req_i when hot_join_en_i=1 and target_ibi_addr_valid_i=0.
- Cleared when the HJ is issued-and-completed, when hot_join_en_i falls, or when target_ibi_addr_valid_i rises.

IDLE:
- If hj_pending=1, latch an HJ request: addr = target_hot_join_addr_i, mdb = 0, is_hj = 1. Go to WAIT_BUS.
- Otherwise, if ibi_req_valid_i & ibi_enable_i & target_ibi_addr_valid_i: pulse ibi_req_ready_o in the same cycle, latch addr and mdb, set is_hj = 0, go to WAIT_BUS.
- HJ has priority when both are eligible.
- ibi_req_ready_o is never asserted outside IDLE.

WAIT_BUS:
- When bus_available_i=1: pulse ibi_start_o (this is the next cycle after entry at the earliest), go to WAIT_DONE.
- If the enable for the latched type drops (ibi_enable_i for IBI, hot_join_en_i for HJ): go to REPORT with status 10.

WAIT_DONE:
- Hold ibi_addr_o, ibi_mdb_o and ibi_is_hj_o stable; they stay stable from latch to REPORT.
- On ibi_done_i with ibi_ack_i=1: REPORT with status 00.
- On ibi_done_i with ibi_ack_i=0:
  - If retry count equals ibi_retry_num_i: REPORT with status 01.
  - Otherwise increment the retry count and go to BACKOFF.
- Disable has no effect in this state; the attempt always runs to completion.

BACKOFF:
- Count BACKOFF_CYCLES, then go to WAIT_BUS.
- A disable while counting goes to REPORT with status 10.

REPORT:
- Pulse status_valid_o for one cycle, clear the retry count, clear hj_pending if the request was an HJ, return to IDLE.
- Back-to-back requests: the next request can be accepted on the cycle after REPORT.

Retry arithmetic:
- The counter is 3 bits and saturates.
- ibi_retry_num_i is sampled live; total attempts = ibi_retry_num_i + 1.
- ibi_retry_num_i = 0 means exactly one attempt.

Other boundary conditions:
- ibi_done_i outside WAIT_DONE is ignored.
- hj_req_i while an HJ is already pending is absorbed (only one HJ is queued).
- Reset mid-operation returns the block to IDLE with no status pulse; the IBI queue entry is lost.

Optional Feature:
- Macro: IBI_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_DONE. Reaching TIMEOUT_CYCLES with no ibi_done_i goes to REPORT with status 11, and the retry count is not consumed. The watchdog clears on every entry to WAIT_DONE.
- Undefined: no watchdog; WAIT_DONE waits indefinitely and status 11 never occurs.

Decomposition:
- Shared package ibi_sched_pkg holds:
  - state enum {IDLE, WAIT_BUS, WAIT_DONE, BACKOFF, REPORT};
  - status constants IBI_ST_OK, IBI_ST_EXHAUSTED, IBI_ST_ABORT, IBI_ST_TIMEOUT;
  - request struct {addr[6:0], mdb[7:0], is_hj}.
- One sub-module, ibi_backoff_timer: a loadable down-counter with an expired flag, reused for BACKOFF and, when compiled in, the watchdog.

Test Plan:
1. ibi_retry_num=0, IBI mdb=8'hA5, addr 7'h2A, ACK on the first attempt -> one ibi_start_o with addr 2A, mdb A5, is_hj=0; status 00; ibi_req_ready_o pulsed once.
2. ibi_retry_num=2, NACK on all attempts -> exactly 3 ibi_start_o pulses, each at least BACKOFF_CYCLES apart; status 01.
3. IBI queue valid and hj_req_i in the same cycle, addr_valid=0 and hot_join_en=1 -> HJ with addr 02 issued; IBI not accepted (addr invalid); status 00; hj_pending cleared.
4. bus_available held 0, ibi_enable dropped in WAIT_BUS -> no ibi_start_o, status 10, back to IDLE.
5. Reset asserted in WAIT_DONE -> all outputs 0 immediately; no status pulse after reset release.
6. With IBI_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ibi_done_i -> status 11 after 8 WAIT_DONE cycles.
